// File: rtl/wb_writer.sv
// Write-back stage: retires ALU/PC results directly and waits for load data before driving the register file write port.
// Optional macro WB_LOAD_EXT_EN formats load data by funct3 (LB/LH/LW/LBU/LHU); otherwise the raw word is written.
module wb_writer #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_wbsel,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_alu,
  input  logic [2:0]  in_funct3,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        write_enable,
  output logic [4:0]  rd,
  output logic [1:0]  WBSel,
  output logic [31:0] PC,
  output logic [31:0] ALU_out,
  output logic [31:0] dmem_out,
  output logic        busy,
  output logic        mem_timeout
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      load_word;

  assign in_ready = (state != WAIT_MEM);
  assign busy     = (state != IDLE);

`ifdef WB_LOAD_EXT_EN
  logic [2:0] funct3_q;

  function automatic logic [31:0] format_load(input logic [2:0] f3, input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = w[7:0];
    h = w[15:0];
    case (f3)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // funct3 must survive the wait for memory, so it is captured with the load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_q <= 3'd0;
    end else if (in_valid && in_ready && in_wbsel == 2'b10) begin
      funct3_q <= in_funct3;
    end
  end

  assign load_word = format_load(funct3_q, dmem_rdata);
`else
  logic unused_funct3;
  assign unused_funct3 = ^in_funct3;
  assign load_word     = dmem_rdata;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      write_enable <= 1'b0;
      mem_timeout  <= 1'b0;
      rd           <= 5'd0;
      WBSel        <= 2'b00;
      PC           <= 32'd0;
      ALU_out      <= 32'd0;
      dmem_out     <= 32'd0;
    end else begin
      write_enable <= 1'b0;
      mem_timeout  <= 1'b0;
      case (state)
        IDLE, COMMIT: begin
          if (in_valid) begin
            case (in_wbsel)
              2'b00, 2'b01: begin
                rd           <= in_rd;
                WBSel        <= in_wbsel;
                PC           <= in_pc;
                ALU_out      <= in_alu;
                write_enable <= (in_rd != 5'd0);
                state        <= COMMIT;
              end
              2'b10: begin
                rd    <= in_rd;
                WBSel <= in_wbsel;
                cnt   <= '0;
                state <= WAIT_MEM;
              end
              default: state <= IDLE;
            endcase
          end else begin
            state <= IDLE;
          end
        end
        WAIT_MEM: begin
          // data arriving on the last allowed cycle still wins over the timeout
          if (dmem_rvalid) begin
            dmem_out     <= load_word;
            write_enable <= (rd != 5'd0);
            state        <= COMMIT;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            mem_timeout <= 1'b1;
            cnt         <= '0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
